series_job_dispatcher: RTL and testbench
========================================

SERIES_JOB_DISPATCHER -- requirements
Module: series_job_dispatcher

Interface
REQ-001 Parameters SHALL be: XW, default 8, operand width; RW, default 16, result width; TIMEOUT, default 255, maximum core busy cycles per job.
REQ-002 Reset SHALL be rst, asynchronous, active-high; clock SHALL be clk.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  host operand valid.
REQ-006 in_x  input  XW  host operand.
REQ-007 in_ready  output  1  dispatcher accepts operand.
REQ-008 core_start  output  1  start pulse to the series compute core.
REQ-009 core_x  output  XW  operand to the core, held for the whole job.
REQ-010 core_done  input  1  core idle/finished flag (high when the core is idle).
REQ-011 core_result  input  RW  core result, valid while core_done=1 after a job.
REQ-012 out_valid  output  1  result available.
REQ-013 out_data  output  RW  captured result.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 err  output  1  sticky timeout flag.
REQ-016 job_cnt  output  8  completed-job counter.

Function
REQ-017 The FSM SHALL have states IDLE, LAUNCH, ACK, RUN, HOLD.
REQ-018 In IDLE, in_ready SHALL equal core_done; all other states SHALL drive in_ready=0.
REQ-019 When in IDLE with in_valid=1 and in_ready=1 at a clock edge, the block SHALL register in_x into x_reg, clear err, and go to LAUNCH.
REQ-020 core_x SHALL always equal x_reg; x_reg SHALL change only on input acceptance.
REQ-021 In LAUNCH, core_start SHALL be 1 for exactly one cycle; next state SHALL be ACK; core_start SHALL be 0 in every other state.
REQ-022 In ACK, the block SHALL wait for core_done=0, then go to RUN.
REQ-023 In RUN, the block SHALL wait for core_done=1; on that edge it SHALL capture core_result into out_data and go to HOLD.
REQ-024 In HOLD, out_valid SHALL be 1; when out_ready=1, the block SHALL go to IDLE and increment job_cnt (modulo 256, 255 wraps to 0); out_valid SHALL be 0 in all other states.
REQ-025 Latency: operand accepted at edge N -> core_start high in cycle N+1; core_done rising seen at edge M in RUN -> out_valid high from cycle M+1.
REQ-026 out_data SHALL remain stable while out_valid=1.
REQ-027 A watchdog SHALL count cycles spent in ACK plus RUN, cleared on entering LAUNCH.
REQ-028 When the watchdog reaches TIMEOUT, the block SHALL set err=1, load out_data with all ones, and go to HOLD, regardless of core_done.
REQ-029 err SHALL stay 1 until the next accepted operand or reset.
REQ-030 A timed-out job SHALL still increment job_cnt on its HOLD handshake.
REQ-031 If in_valid=1 while in_ready=0, no operand SHALL be taken; the host holds in_x.

Reset
REQ-032 While rst=1, the FSM SHALL be in IDLE, with core_start=0, out_valid=0, out_data=0, x_reg=0, err=0, job_cnt=0, and the watchdog at 0.
REQ-033 Reset asserted mid-job SHALL abort the job immediately; no result SHALL be output and job_cnt SHALL be unchanged from 0.

Verification
REQ-034 Normal job: in_x=8'h05 accepted; core model drops done 1 cycle after start and raises it 6 cycles later with result 16'h1234 -> single start pulse, core_x=05 throughout, out_valid with out_data=1234, job_cnt=1 after out_ready.
REQ-035 Back-pressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid and out_data stable, in_ready=0, job_cnt unchanged until out_ready=1.
REQ-036 Core busy at entry: core_done=0 in IDLE with in_valid=1 -> in_ready=0, no start; raise core_done -> accepted next edge.
REQ-037 Timeout with TIMEOUT=8: core never raises done -> after 8 ACK/RUN cycles, err=1 and out_data=16'hFFFF; err clears on the next accepted operand.
REQ-038 Reset mid-RUN -> out_valid=0, core_start=0, job_cnt=0, in_ready follows core_done on the next cycle.
REQ-039 Counter wrap: 256 back-to-back jobs -> job_cnt returns to 0.

Source files
------------

// File: rtl/series_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : series_job_dispatcher
// Purpose  : Hands one operand at a time to a series compute core, waits for
//            the core to finish (with a watchdog), and presents the result to
//            a downstream consumer with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module series_job_dispatcher #(
    parameter int XW      = 8,
    parameter int RW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    output logic          in_ready,
    output logic          core_start,
    output logic [XW-1:0] core_x,
    input  logic          core_done,
    input  logic [RW-1:0] core_result,
    output logic          out_valid,
    output logic [RW-1:0] out_data,
    input  logic          out_ready,
    output logic          err,
    output logic [7:0]    job_cnt
);

    // The watchdog only ever holds 0 .. TIMEOUT-1; the last value triggers
    // the timeout, so it never needs to represent TIMEOUT itself.
    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WDW-1:0] c_wd_last = WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ACK    = 3'd2,
        RUN    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [XW-1:0]   r_x;
    logic [WDW-1:0]  r_wd;
    logic [RW-1:0]   r_out_data;
    logic            r_err;
    logic [7:0]      r_job_cnt;

    logic            w_accept;
    logic            w_capture;
    logic            w_timeout;
    logic            w_release;
    logic            w_wd_count;

    assign core_x   = r_x;
    assign out_data = r_out_data;
    assign err      = r_err;
    assign job_cnt  = r_job_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, handshake outputs and per-edge event strobes.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        w_accept   = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        w_release  = 1'b0;
        w_wd_count = 1'b0;
        case (r_state)
            IDLE: begin
                // A busy core blocks acceptance even before the first job.
                in_ready = core_done;
                if (in_valid && core_done) begin
                    w_accept = 1'b1;
                    w_next   = LAUNCH;
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
                w_next     = ACK;
            end
            ACK: begin
                // Timeout wins over any core_done activity on the same edge.
                if (r_wd == c_wd_last) begin
                    w_timeout = 1'b1;
                    w_next    = HOLD;
                end else begin
                    w_wd_count = 1'b1;
                    if (!core_done) begin
                        w_next = RUN;
                    end
                end
            end
            RUN: begin
                if (r_wd == c_wd_last) begin
                    w_timeout = 1'b1;
                    w_next    = HOLD;
                end else begin
                    w_wd_count = 1'b1;
                    if (core_done) begin
                        w_capture = 1'b1;
                        w_next    = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand register: loaded only when the host handshake completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
        end else if (w_accept) begin
            r_x <= in_x;
        end
    end

    // Watchdog over ACK+RUN; restarted at acceptance so LAUNCH begins at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd <= '0;
        end else if (w_accept) begin
            r_wd <= '0;
        end else if (w_wd_count) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Result register: core result on completion, all ones on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
        end else if (w_timeout) begin
            r_out_data <= '1;
        end else if (w_capture) begin
            r_out_data <= core_result;
        end
    end

    // Sticky timeout flag, cleared only by the next accepted operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    // Completed-job counter, bumped on the result handshake (wraps mod 256).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_job_cnt <= 8'd0;
        end else if (w_release) begin
            r_job_cnt <= r_job_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_series_job_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_series_job_dispatcher
// Purpose  : Directed self-checking bench for series_job_dispatcher with a
//            small behavioural core model (TIMEOUT = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_series_job_dispatcher;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_x;
    logic        in_ready;
    logic        core_start;
    logic [7:0]  core_x;
    logic        core_done;
    logic [15:0] core_result;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        err;
    logic [7:0]  job_cnt;

    // Core model controls
    logic        core_manual;
    logic        man_done;
    logic [15:0] man_res;
    logic        core_hang;
    logic [15:0] m_res;
    logic        m_done;
    int          m_cnt;

    int tests;
    int fails;

    series_job_dispatcher #(.XW(8), .RW(16), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_x        (in_x),
        .in_ready    (in_ready),
        .core_start  (core_start),
        .core_x      (core_x),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err         (err),
        .job_cnt     (job_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: done drops on the edge that sees start, and rises again
    // after six low cycles unless hung.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done <= 1'b1;
            m_cnt  <= 0;
        end else if (core_start && !core_manual) begin
            m_done <= 1'b0;
            m_cnt  <= 6;
        end else if (!m_done && !core_hang && m_cnt > 0) begin
            if (m_cnt == 1) m_done <= 1'b1;
            m_cnt <= m_cnt - 1;
        end
    end

    assign core_done   = core_manual ? man_done : m_done;
    assign core_result = core_manual ? man_res  : (m_done ? m_res : 16'hDEAD);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++; if (core_start !== 1'b0) begin fails++; $display("FAIL rst_core_start got %b exp 0", core_start); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 16'h0000) begin fails++; $display("FAIL rst_out_data got %h exp 0000", out_data); end
        tests++; if (core_x !== 8'h00) begin fails++; $display("FAIL rst_core_x got %h exp 00", core_x); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", err); end
        tests++; if (job_cnt !== 8'd0) begin fails++; $display("FAIL rst_job_cnt got %0d exp 0", job_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_normal;
        int cyc;
        int starts;
        int bad_x;
        cyc = 0; starts = 0; bad_x = 0;
        m_res    = 16'h1234;
        in_x     = 8'h05;
        in_valid = 1'b1;
        tick();
        tests++; if (core_start !== 1'b1) begin fails++; $display("FAIL norm_start got %b exp 1", core_start); end
        tests++; if (core_x !== 8'h05) begin fails++; $display("FAIL norm_core_x got %h exp 05", core_x); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL norm_in_ready got %b exp 0", in_ready); end
        in_valid = 1'b0;
        in_x     = 8'hAA;
        for (int i = 0; i < 30; i++) begin
            tick();
            cyc++;
            if (core_start === 1'b1) starts++;
            if (core_x !== 8'h05) bad_x++;
            if (out_valid === 1'b1) break;
        end
        tests++; if (cyc !== 8) begin fails++; $display("FAIL norm_latency got %0d exp 8", cyc); end
        tests++; if (starts !== 0) begin fails++; $display("FAIL norm_extra_start got %0d exp 0", starts); end
        tests++; if (bad_x !== 0) begin fails++; $display("FAIL norm_x_hold got %0d bad exp 0", bad_x); end
        tests++; if (out_data !== 16'h1234) begin fails++; $display("FAIL norm_out_data got %h exp 1234", out_data); end
        tests++; if (job_cnt !== 8'd0) begin fails++; $display("FAIL norm_cnt_before got %0d exp 0", job_cnt); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL norm_valid_drop got %b exp 0", out_valid); end
        tests++; if (job_cnt !== 8'd1) begin fails++; $display("FAIL norm_cnt got %0d exp 1", job_cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL norm_in_ready_back got %b exp 1", in_ready); end
    endtask

    task automatic test_backpressure;
        m_res    = 16'hBEEF;
        in_x     = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_wait got %b exp 1", out_valid); end
        m_res = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 16'hBEEF || in_ready !== 1'b0 || job_cnt !== 8'd1) begin
                fails++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h r=%b c=%0d exp v=1 d=beef r=0 c=1",
                         i, out_valid, out_data, in_ready, job_cnt);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (job_cnt !== 8'd2) begin fails++; $display("FAIL bp_cnt got %0d exp 2", job_cnt); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_drop got %b exp 0", out_valid); end
    endtask

    task automatic test_busy_entry;
        int bad;
        bad = 0;
        man_done    = 1'b0;
        man_res     = 16'h0000;
        core_manual = 1'b1;
        in_x        = 8'h77;
        in_valid    = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (in_ready !== 1'b0 || core_start !== 1'b0) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL busy_blocked got %0d bad cycles exp 0", bad); end
        tests++; if (core_x !== 8'h3C) begin fails++; $display("FAIL busy_x_kept got %h exp 3c", core_x); end
        man_done = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL busy_ready got %b exp 1", in_ready); end
        tick();
        tests++; if (core_start !== 1'b1 || core_x !== 8'h77) begin fails++; $display("FAIL busy_accept got start=%b x=%h exp 1 77", core_start, core_x); end
        in_valid = 1'b0;
        man_done = 1'b0;
        tick();
        tick();
        man_res  = 16'h0042;
        man_done = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 16'h0042) begin fails++; $display("FAIL busy_result got v=%b d=%h exp 1 0042", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready   = 1'b0;
        core_manual = 1'b0;
        tests++; if (job_cnt !== 8'd3) begin fails++; $display("FAIL busy_cnt got %0d exp 3", job_cnt); end
    endtask

    task automatic test_timeout;
        int cyc;
        cyc = 0;
        core_hang = 1'b1;
        in_x      = 8'h11;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cyc++;
            if (out_valid === 1'b1) break;
        end
        tests++; if (cyc !== 9) begin fails++; $display("FAIL to_latency got %0d exp 9", cyc); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err got %b exp 1", err); end
        tests++; if (out_data !== 16'hFFFF) begin fails++; $display("FAIL to_out_data got %h exp ffff", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (job_cnt !== 8'd4) begin fails++; $display("FAIL to_cnt got %0d exp 4", job_cnt); end
        core_hang = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) break;
            tick();
        end
        tests++; if (in_ready !== 1'b1 || err !== 1'b1) begin fails++; $display("FAIL to_err_sticky got r=%b e=%b exp 1 1", in_ready, err); end
        m_res    = 16'h2222;
        in_x     = 8'h22;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_err_clear got %b exp 0", err); end
        for (int i = 0; i < 30; i++) begin
            if (out_valid === 1'b1) break;
            tick();
        end
        tests++; if (out_valid !== 1'b1 || out_data !== 16'h2222 || err !== 1'b0) begin fails++; $display("FAIL to_next_job got v=%b d=%h e=%b exp 1 2222 0", out_valid, out_data, err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (job_cnt !== 8'd5) begin fails++; $display("FAIL to_next_cnt got %0d exp 5", job_cnt); end
    endtask

    task automatic test_reset_mid_run;
        int bad;
        bad = 0;
        m_res    = 16'h5555;
        in_x     = 8'h55;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || core_start !== 1'b0) begin fails++; $display("FAIL mid_rst_outs got v=%b s=%b exp 0 0", out_valid, core_start); end
        tests++; if (job_cnt !== 8'd0 || err !== 1'b0 || core_x !== 8'h00) begin fails++; $display("FAIL mid_rst_regs got c=%0d e=%b x=%h exp 0 0 00", job_cnt, err, core_x); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0 || job_cnt !== 8'd0) bad++;
            tick();
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL mid_rst_no_result got %0d bad cycles exp 0", bad); end
    endtask

    task automatic test_back_to_back_wrap;
        int  hc;
        logic hs;
        hc        = 0;
        m_res     = 16'h1234;
        in_x      = 8'h01;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6000 && hc < 256; i++) begin
            hs = out_valid;
            tick();
            if (hs === 1'b1) begin
                hc++;
                if (hc == 255) begin
                    tests++; if (job_cnt !== 8'd255) begin fails++; $display("FAIL wrap_255 got %0d exp 255", job_cnt); end
                end
                if (hc == 256) begin
                    tests++; if (job_cnt !== 8'd0) begin fails++; $display("FAIL wrap_0 got %0d exp 0", job_cnt); end
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++; if (hc !== 256) begin fails++; $display("FAIL wrap_jobs got %0d exp 256", hc); end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_x        = 8'h00;
        out_ready   = 1'b0;
        core_manual = 1'b0;
        man_done    = 1'b1;
        man_res     = 16'h0000;
        core_hang   = 1'b0;
        m_res       = 16'h0000;

        test_reset();
        test_normal();
        test_backpressure();
        test_busy_entry();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back_wrap();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
